// File: rtl/demux_stream_pkg.sv
// Shared constants for the demux_stream block.
// Channel indices, default buffer depth and event-counter width.
package demux_stream_pkg;

   localparam int BUF_DEPTH_DEF = 2;
   localparam int CNT_W = 16;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef enum logic {
      SEL_A = CH_A,
      SEL_B = CH_B
   } ch_sel_e;

   typedef struct packed {
      logic full;
      logic empty;
   } buf_stat_t;

   // Pointer width for a power-of-two depth (never narrower than 1 bit)
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/demux_buf.sv
// Per-channel synchronous FIFO for demux_stream.
// Push is ignored when full, pop is ignored when empty; head reads 0 when empty.
module demux_buf
   import demux_stream_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = BUF_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output buf_stat_t     stat
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] wr_ptr_d;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          do_push;
   logic          do_pop;

   assign stat.full  = (cnt_q == DEPTH_C);
   assign stat.empty = (cnt_q == '0);

   // A full buffer refuses a push even when it pops in the same cycle
   assign do_push = push && !stat.full;
   assign do_pop  = pop && !stat.empty;

   assign head_data = stat.empty ? '0 : mem_q[rd_ptr_q];

   // Next-state: write at tail, advance pointers (wrap by power-of-two width)
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset empties the buffer and clears storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer with a small FIFO per output channel.
// Optional per-channel transfer counters when DEMUX_STREAM_CNT_EN is defined.
module demux_stream
   import demux_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  c,
   output logic [DATA_WIDTH-1:0] out_a_data,
   output logic                  out_a_valid,
   input  logic                  out_a_ready,
   output logic [DATA_WIDTH-1:0] out_b_data,
   output logic                  out_b_valid,
   input  logic                  out_b_ready
`ifdef DEMUX_STREAM_CNT_EN
   ,
   output logic [CNT_W-1:0]      cnt_a,
   output logic [CNT_W-1:0]      cnt_b
`endif
);

   ch_sel_e   sel;
   buf_stat_t stat_a;
   buf_stat_t stat_b;
   logic      sel_full;
   logic      xfer;
   logic      push_a;
   logic      push_b;

   assign sel = ch_sel_e'(c);

   // Ready only looks at the selected buffer, never at downstream ready
   always_comb begin
      sel_full = stat_a.full;
      if (sel == SEL_B) begin
         sel_full = stat_b.full;
      end
   end

   assign in_ready = !sel_full;
   assign xfer     = in_valid && in_ready;
   assign push_a   = xfer && (sel == SEL_A);
   assign push_b   = xfer && (sel == SEL_B);

   assign out_a_valid = !stat_a.empty;
   assign out_b_valid = !stat_b.empty;

   demux_buf #(
      .DW    (DATA_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf_a (
      .clk       (clk),
      .rst       (rst),
      .push      (push_a),
      .push_data (in_data),
      .pop       (out_a_ready),
      .head_data (out_a_data),
      .stat      (stat_a)
   );

   demux_buf #(
      .DW    (DATA_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf_b (
      .clk       (clk),
      .rst       (rst),
      .push      (push_b),
      .push_data (in_data),
      .pop       (out_b_ready),
      .head_data (out_b_data),
      .stat      (stat_b)
   );

`ifdef DEMUX_STREAM_CNT_EN
   logic [CNT_W-1:0] cnt_a_q;
   logic [CNT_W-1:0] cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q;
   logic [CNT_W-1:0] cnt_b_d;

   // Count accepted input words per channel; wraps at the top value
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (push_a) begin
         cnt_a_d = cnt_a_q + CNT_W'(1);
      end
      if (push_b) begin
         cnt_b_d = cnt_b_q + CNT_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Randomized scoreboard bench for demux_stream.
// Directed scenarios first, then random traffic with occasional resets.
module tb_demux_stream;

   localparam int DW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          c = 1'b0;
   logic [DW-1:0] out_a_data;
   logic          out_a_valid;
   logic          out_a_ready = 1'b0;
   logic [DW-1:0] out_b_data;
   logic          out_b_valid;
   logic          out_b_ready = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
   logic [15:0]   cnt_a;
   logic [15:0]   cnt_b;
   logic [15:0]   m_cnt_a = '0;
   logic [15:0]   m_cnt_b = '0;
`endif

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   bit            exp_rdy;
   bit            a_has;
   bit            b_has;

   demux_stream #(
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .c           (c),
      .out_a_data  (out_a_data),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready)
`ifdef DEMUX_STREAM_CNT_EN
      ,
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Monitor/scoreboard: sample 1 time unit before each rising edge
   always begin
      @(negedge clk);
      #4;
      if (rst) begin
         chk("rst_a_valid", out_a_valid, 0);
         chk("rst_b_valid", out_b_valid, 0);
         chk("rst_a_data", out_a_data, 0);
         chk("rst_b_data", out_b_data, 0);
         chk("rst_in_ready", in_ready, 1);
         qa.delete();
         qb.delete();
`ifdef DEMUX_STREAM_CNT_EN
         chk("rst_cnt_a", cnt_a, 0);
         chk("rst_cnt_b", cnt_b, 0);
         m_cnt_a = '0;
         m_cnt_b = '0;
`endif
      end else begin
         a_has   = (qa.size() != 0);
         b_has   = (qb.size() != 0);
         exp_rdy = c ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
         chk("in_ready", in_ready, exp_rdy);
         chk("a_valid", out_a_valid, a_has);
         chk("b_valid", out_b_valid, b_has);
         if (a_has) chk("a_data", out_a_data, qa[0]);
         if (b_has) chk("b_data", out_b_data, qb[0]);
`ifdef DEMUX_STREAM_CNT_EN
         chk("cnt_a", cnt_a, m_cnt_a);
         chk("cnt_b", cnt_b, m_cnt_b);
`endif
         if (a_has && out_a_ready) void'(qa.pop_front());
         if (b_has && out_b_ready) void'(qb.pop_front());
         if (in_valid && exp_rdy) begin
            if (c) qb.push_back(in_data);
            else   qa.push_back(in_data);
`ifdef DEMUX_STREAM_CNT_EN
            if (c) m_cnt_b = m_cnt_b + 16'd1;
            else   m_cnt_a = m_cnt_a + 16'd1;
`endif
         end
      end
   end

   task automatic drive(input bit v, input bit cc, input logic [DW-1:0] d,
                        input bit ra, input bit rb);
      @(negedge clk);
      in_valid    = v;
      c           = cc;
      in_data     = d;
      out_a_ready = ra;
      out_b_ready = rb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0);
   endtask

   task automatic pulse_rst(input int n);
      @(negedge clk);
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(1);

      // single word to channel a, latency 1
      drive(1, 0, 8'hA5, 0, 0);
      idle(1);
      drive(0, 0, 8'h00, 1, 0);

      // fill channel b, then probe ready for both selects
      drive(1, 1, 8'h11, 0, 0);
      drive(1, 1, 8'h22, 0, 0);
      drive(1, 1, 8'h33, 0, 0);
      drive(0, 0, 8'h00, 0, 0);

      // full b pops while input is offered: pop only, push next cycle
      drive(1, 1, 8'h33, 0, 1);
      drive(1, 1, 8'h33, 0, 0);
      drive(0, 0, 8'h00, 0, 1);
      drive(0, 0, 8'h00, 0, 1);
      idle(1);

      // alternating channels with both readies high
      for (int i = 1; i <= 8; i++) begin
         drive(1, (i % 2 == 0), DW'(i), 1, 1);
      end
      drive(0, 0, 8'h00, 1, 1);
      drive(0, 0, 8'h00, 1, 1);

      // reset with both channels holding data
      drive(1, 0, 8'h41, 0, 0);
      drive(1, 0, 8'h42, 0, 0);
      drive(1, 1, 8'h51, 0, 0);
      drive(0, 0, 8'h00, 0, 0);
      pulse_rst(2);
      drive(1, 0, 8'h61, 0, 0);
      drive(1, 1, 8'h71, 0, 0);
      idle(1);
      drive(0, 0, 8'h00, 1, 1);
      idle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_rst($urandom_range(1, 2));
         end else begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  DW'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
         end
      end
      drive(0, 0, 8'h00, 1, 1);
      drive(0, 0, 8'h00, 1, 1);
      idle(1);

`ifdef DEMUX_STREAM_CNT_EN
      // counter wrap: 65537 words on channel a from reset
      pulse_rst(1);
      for (int i = 0; i < 65537; i++) begin
         drive(1, 0, DW'(i), 1, 0);
      end
      drive(0, 0, 8'h00, 1, 0);
      @(negedge clk);
      #4;
      chk("cnt_a_65537", cnt_a, 1);
      chk("cnt_b_65537", cnt_b, 0);
`endif

      @(negedge clk);
      #6;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
